stepper_pulse_sequencer: RTL and testbench

- Per-axis step/dir pulse generator that executes one move command written by the HPS through the stepper_N steps_out/speed PIOs.
- Reports progress on the matching steps_in PIO and raises done/fault into flags_in.
- Honours the axis min-endstop.
- One instance per axis (4 total), instantiated in the FPGA top level beside soc_system.

---
 rtl/stepper_pulse_sequencer.sv | 240 ++++++++++++++++++++++++
 tb/tb_stepper_pulse_sequencer.sv | 402 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stepper_pulse_sequencer.sv
// Per-axis step/dir pulse generator executing one HPS move command with endstop and abort handling.
// Optional build macro STEPPER_POS_TRACK_EN adds a signed step position counter output.
module stepper_pulse_sequencer #(
    parameter int PULSE_W    = 20,
    parameter int DIR_SETUP  = 50,
    parameter int MIN_PERIOD = 100
) (
    input  logic        clk_clk,
    input  logic        reset_reset_n,
    input  logic [31:0] cmd_word,
    input  logic [31:0] cmd_period,
    input  logic        cmd_go,
    input  logic        cmd_abort,
    input  logic        endstop_min_n,
    output logic        step,
    output logic        dir,
    output logic [31:0] status_word,
    output logic        done,
    output logic        fault
`ifdef STEPPER_POS_TRACK_EN
    ,
    output logic signed [31:0] position
`endif
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_HIGH  = 3'd2,
        ST_LOW   = 3'd3,
        ST_HALT  = 3'd4
    } state_t;

    localparam logic [31:0] PULSE_W_C    = 32'(PULSE_W);
    localparam logic [31:0] PULSE_LOAD   = 32'(PULSE_W - 1);
    localparam logic [31:0] SETUP_LOAD   = 32'(DIR_SETUP - 1);
    localparam logic [31:0] MIN_PERIOD_C = 32'(MIN_PERIOD);

    state_t      state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic [31:0] period_q, period_d;
    logic [30:0] steps_tgt_q, steps_tgt_d;
    logic [30:0] steps_done_q, steps_done_d;
    logic        dir_q, dir_d;
    logic        done_q, done_d;
    logic        fault_q, fault_d;
    logic        step_q, busy_q;
    logic        go_q, go_q2, abort_q;
    logic        es_meta_q, es_sync_q;

    logic        go_pulse_s;
    logic        endstop_hit_s;
    logic        stop_s;
    logic        step_done_s;
    logic        busy_d_s;
    logic [31:0] period_clamped_s;
    logic [30:0] steps_inc_s;

    // Input registration: go/abort single stage, endstop two-stage synchroniser preset to "not hit"
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            go_q      <= 1'b0;
            go_q2     <= 1'b0;
            abort_q   <= 1'b0;
            es_meta_q <= 1'b1;
            es_sync_q <= 1'b1;
        end else begin
            go_q      <= cmd_go;
            go_q2     <= go_q;
            abort_q   <= cmd_abort;
            es_meta_q <= endstop_min_n;
            es_sync_q <= es_meta_q;
        end
    end

    assign go_pulse_s       = go_q & ~go_q2;
    assign endstop_hit_s    = ~es_sync_q;
    // The endstop only stops motion towards the switch, so the axis can back off it.
    assign stop_s           = abort_q | (endstop_hit_s & ~dir_q);
    assign period_clamped_s = (cmd_period < MIN_PERIOD_C) ? MIN_PERIOD_C : cmd_period;
    assign steps_inc_s      = steps_done_q + 31'd1;

    // Next-state and datapath decisions for the move sequencer
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        period_d     = period_q;
        steps_tgt_d  = steps_tgt_q;
        steps_done_d = steps_done_q;
        dir_d        = dir_q;
        done_d       = done_q;
        fault_d      = fault_q;
        step_done_s  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (go_pulse_s) begin
                    dir_d        = cmd_word[31];
                    steps_tgt_d  = cmd_word[30:0];
                    steps_done_d = 31'd0;
                    done_d       = 1'b0;
                    fault_d      = 1'b0;
                    if (cmd_word[30:0] == 31'd0) begin
                        state_d = ST_HALT;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_SETUP;
                        cnt_d   = SETUP_LOAD;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SETUP: begin
                if (stop_s) begin
                    fault_d = 1'b1;
                    state_d = ST_HALT;
                end else if (cnt_q == 32'd0) begin
                    state_d  = ST_HIGH;
                    cnt_d    = PULSE_LOAD;
                    period_d = period_clamped_s;
                end else begin
                    cnt_d = cnt_q - 32'd1;
                end
            end
            ST_HIGH: begin
                // Stop requests wait for the pulse to finish so the driver never sees a runt.
                if (cnt_q == 32'd0) begin
                    step_done_s = 1'b1;
                    if (stop_s) begin
                        state_d = ST_HALT;
                        if (steps_inc_s == steps_tgt_q) begin
                            done_d = 1'b1;
                        end else begin
                            fault_d = 1'b1;
                        end
                    end else begin
                        state_d = ST_LOW;
                        cnt_d   = period_q - PULSE_W_C - 32'd1;
                    end
                end else begin
                    cnt_d = cnt_q - 32'd1;
                end
            end
            ST_LOW: begin
                if (stop_s) begin
                    state_d = ST_HALT;
                    if (steps_done_q == steps_tgt_q) begin
                        done_d = 1'b1;
                    end else begin
                        fault_d = 1'b1;
                    end
                end else if (cnt_q == 32'd0) begin
                    if (steps_done_q == steps_tgt_q) begin
                        done_d  = 1'b1;
                        state_d = ST_HALT;
                    end else begin
                        state_d  = ST_HIGH;
                        cnt_d    = PULSE_LOAD;
                        period_d = period_clamped_s;
                    end
                end else begin
                    cnt_d = cnt_q - 32'd1;
                end
            end
            ST_HALT: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (step_done_s) begin
            steps_done_d = steps_inc_s;
        end else begin
            steps_done_d = steps_done_d;
        end
    end

    assign busy_d_s = (state_d == ST_SETUP) || (state_d == ST_HIGH) || (state_d == ST_LOW);

    // Sequencer state, counters and registered outputs
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= 32'd0;
            period_q     <= 32'd0;
            steps_tgt_q  <= 31'd0;
            steps_done_q <= 31'd0;
            dir_q        <= 1'b0;
            done_q       <= 1'b0;
            fault_q      <= 1'b0;
            step_q       <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            period_q     <= period_d;
            steps_tgt_q  <= steps_tgt_d;
            steps_done_q <= steps_done_d;
            dir_q        <= dir_d;
            done_q       <= done_d;
            fault_q      <= fault_d;
            step_q       <= (state_d == ST_HIGH);
            busy_q       <= busy_d_s;
        end
    end

    assign step        = step_q;
    assign dir         = dir_q;
    assign status_word = {busy_q, steps_done_q};
    assign done        = done_q;
    assign fault       = fault_q;

`ifdef STEPPER_POS_TRACK_EN
    logic signed [31:0] pos_q;
    logic               es_hit_prev_q;

    // Position tracking; a fresh endstop hit while idle re-references the axis to zero
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            pos_q         <= 32'sd0;
            es_hit_prev_q <= 1'b0;
        end else begin
            es_hit_prev_q <= endstop_hit_s;
            if ((state_q == ST_IDLE) && endstop_hit_s && !es_hit_prev_q) begin
                pos_q <= 32'sd0;
            end else if (step_done_s) begin
                pos_q <= dir_q ? (pos_q + 32'sd1) : (pos_q - 32'sd1);
            end else begin
                pos_q <= pos_q;
            end
        end
    end

    assign position = pos_q;
`endif

endmodule

// File: tb/tb_stepper_pulse_sequencer.sv
// Directed self-checking bench for stepper_pulse_sequencer (default parameters).
module tb_stepper_pulse_sequencer;

    localparam int PW = 20;
    localparam int DS = 50;

    logic        clk_clk       = 1'b0;
    logic        reset_reset_n = 1'b0;
    logic [31:0] cmd_word      = 32'd0;
    logic [31:0] cmd_period    = 32'd0;
    logic        cmd_go        = 1'b0;
    logic        cmd_abort     = 1'b0;
    logic        endstop_min_n = 1'b1;
    logic        step, dir, done, fault;
    logic [31:0] status_word;
`ifdef STEPPER_POS_TRACK_EN
    logic signed [31:0] position;
`endif

    stepper_pulse_sequencer dut (
        .clk_clk       (clk_clk),
        .reset_reset_n (reset_reset_n),
        .cmd_word      (cmd_word),
        .cmd_period    (cmd_period),
        .cmd_go        (cmd_go),
        .cmd_abort     (cmd_abort),
        .endstop_min_n (endstop_min_n),
        .step          (step),
        .dir           (dir),
        .status_word   (status_word),
        .done          (done),
        .fault         (fault)
`ifdef STEPPER_POS_TRACK_EN
        ,
        .position      (position)
`endif
    );

    always #5 clk_clk = ~clk_clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int go_cyc   = 0;

    always @(posedge clk_clk) cyc <= cyc + 1;

    // Step monitor: rise times and pulse widths
    int   rises  = 0;
    int   bad_w  = 0;
    int   hi_len = 0;
    logic prev_step = 1'b0;
    int   rise_cyc [0:4095];

    always @(negedge clk_clk) begin
        if (step && !prev_step) begin
            if (rises < 4096) rise_cyc[rises] <= cyc;
            rises  <= rises + 1;
            hi_len <= 1;
        end else if (step) begin
            hi_len <= hi_len + 1;
        end else if (prev_step) begin
            if (hi_len != PW) bad_w <= bad_w + 1;
        end
        prev_step <= step;
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk_clk);
            #1;
        end
    endtask

    task automatic start_move(input logic [31:0] word, input logic [31:0] period);
        cmd_word   = word;
        cmd_period = period;
        cmd_go     = 1'b1;
        go_cyc     = cyc;
        tick(3);
        cmd_go     = 1'b0;
    endtask

    task automatic wait_end(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (done || fault) break;
            tick(1);
        end
    endtask

    task automatic wait_rises(input int target, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (rises >= target) break;
            tick(1);
        end
    endtask

    task automatic test_reset;
        reset_reset_n = 1'b0;
        tick(3);
        checks++;
        if ({step, dir, done, fault, status_word} !== 36'd0) begin
            failures++;
            $display("FAIL reset_outputs: got step=%0b dir=%0b done=%0b fault=%0b status=%h expected all 0",
                     step, dir, done, fault, status_word);
        end
        reset_reset_n = 1'b1;
        tick(3);
    endtask

    task automatic test_basic;
        int base, bw, sp_err;
        base = rises; bw = bad_w; sp_err = 0;
        start_move(32'h8000_0005, 32'd200);
        tick(60);
        checks++;
        if ({status_word[31], dir} !== 2'b11) begin
            failures++;
            $display("FAIL basic_busy_dir: got busy=%0b dir=%0b expected 1 1", status_word[31], dir);
        end
        wait_end(1500);
        checks++;
        if ({done, fault} !== 2'b10) begin
            failures++;
            $display("FAIL basic_flags: got done=%0b fault=%0b expected 1 0", done, fault);
        end
        checks++;
        if (status_word !== 32'h0000_0005) begin
            failures++;
            $display("FAIL basic_status: got %h expected 00000005", status_word);
        end
        checks++;
        if (rises - base !== 5) begin
            failures++;
            $display("FAIL basic_pulses: got %0d expected 5", rises - base);
        end
        checks++;
        if (bad_w !== bw) begin
            failures++;
            $display("FAIL basic_width: got %0d bad widths expected 0", bad_w - bw);
        end
        checks++;
        if (rise_cyc[base] - go_cyc !== DS + 2) begin
            failures++;
            $display("FAIL basic_setup: got %0d cycles expected %0d", rise_cyc[base] - go_cyc, DS + 2);
        end
        for (int i = 1; i < 5; i++) if (rise_cyc[base+i] - rise_cyc[base+i-1] != 200) sp_err++;
        checks++;
        if (sp_err !== 0) begin
            failures++;
            $display("FAIL basic_spacing: got %0d wrong spacings expected 0", sp_err);
        end
    endtask

    task automatic test_clamp;
        int base, sp_err;
        base = rises; sp_err = 0;
        start_move(32'h8000_0003, 32'd10);
        wait_end(1000);
        checks++;
        if (rises - base !== 3) begin
            failures++;
            $display("FAIL clamp_pulses: got %0d expected 3", rises - base);
        end
        for (int i = 1; i < 3; i++) if (rise_cyc[base+i] - rise_cyc[base+i-1] != 100) sp_err++;
        checks++;
        if (sp_err !== 0) begin
            failures++;
            $display("FAIL clamp_spacing: got %0d wrong spacings expected 0", sp_err);
        end
        checks++;
        if ({done, fault, status_word} !== {2'b10, 32'h0000_0003}) begin
            failures++;
            $display("FAIL clamp_end: got done=%0b fault=%0b status=%h expected 1 0 00000003",
                     done, fault, status_word);
        end
    endtask

    task automatic test_zero;
        int base, done_at;
        logic busy_seen;
        base = rises; done_at = -1; busy_seen = 1'b0;
        cmd_word = 32'h0000_0000; cmd_period = 32'd200; cmd_go = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick(1);
            if (i == 2) cmd_go = 1'b0;
            if (status_word[31]) busy_seen = 1'b1;
            if (done && done_at < 0) done_at = i;
        end
        checks++;
        if (!(done_at >= 0 && done_at < 4)) begin
            failures++;
            $display("FAIL zero_done: got done at tick %0d expected 0..3", done_at);
        end
        checks++;
        if (busy_seen !== 1'b0) begin
            failures++;
            $display("FAIL zero_busy: got busy_seen=%0b expected 0", busy_seen);
        end
        checks++;
        if (rises - base !== 0) begin
            failures++;
            $display("FAIL zero_pulses: got %0d expected 0", rises - base);
        end
        checks++;
        if ({fault, status_word} !== 33'd0) begin
            failures++;
            $display("FAIL zero_status: got fault=%0b status=%h expected 0 00000000", fault, status_word);
        end
    endtask

    task automatic test_endstop_dir0;
        int base, n;
        base = rises; n = -1;
        start_move(32'd1000, 32'd100);
        wait_rises(base + 7, 2000);
        tick(30);
        endstop_min_n = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            tick(1);
            if (fault) begin n = i; break; end
        end
        checks++;
        if (!(n >= 1 && n <= 4)) begin
            failures++;
            $display("FAIL endstop_latency: got %0d ticks expected 1..4", n);
        end
        checks++;
        if (!(status_word == 32'd7 || status_word == 32'd8)) begin
            failures++;
            $display("FAIL endstop_status: got %h expected 00000007 or 00000008", status_word);
        end
        checks++;
        if ({done, fault} !== 2'b01) begin
            failures++;
            $display("FAIL endstop_flags: got done=%0b fault=%0b expected 0 1", done, fault);
        end
        endstop_min_n = 1'b1;
        tick(4);
    endtask

    task automatic test_endstop_dir1;
        int base;
        base = rises;
        endstop_min_n = 1'b0;
        tick(4);
        start_move(32'h8000_012C, 32'd100);
        wait_end(31000);
        checks++;
        if ({done, fault} !== 2'b10) begin
            failures++;
            $display("FAIL backoff_flags: got done=%0b fault=%0b expected 1 0", done, fault);
        end
        checks++;
        if (status_word !== 32'h0000_012C) begin
            failures++;
            $display("FAIL backoff_status: got %h expected 0000012c", status_word);
        end
        checks++;
        if (rises - base !== 300) begin
            failures++;
            $display("FAIL backoff_pulses: got %0d expected 300", rises - base);
        end
        endstop_min_n = 1'b1;
        tick(4);
    endtask

    task automatic test_abort;
        int base, bw;
        base = rises; bw = bad_w;
        start_move(32'd10, 32'd200);
        wait_rises(base + 3, 2000);
        tick(5);
        cmd_abort = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (fault) break;
            tick(1);
        end
        checks++;
        if ({done, fault} !== 2'b01) begin
            failures++;
            $display("FAIL abort_flags: got done=%0b fault=%0b expected 0 1", done, fault);
        end
        checks++;
        if (status_word !== 32'h0000_0003) begin
            failures++;
            $display("FAIL abort_status: got %h expected 00000003", status_word);
        end
        checks++;
        if (bad_w !== bw) begin
            failures++;
            $display("FAIL abort_width: got %0d truncated pulses expected 0", bad_w - bw);
        end
        checks++;
        if (rises - base !== 3) begin
            failures++;
            $display("FAIL abort_pulses: got %0d expected 3", rises - base);
        end
        cmd_abort = 1'b0;
        tick(4);
    endtask

    task automatic test_back_to_back;
        int base;
        base = rises;
        start_move(32'd4, 32'd100);
        wait_rises(base + 1, 500);
        start_move(32'h8000_0063, 32'd100);
        wait_end(1000);
        checks++;
        if ({done, fault, status_word} !== {2'b10, 32'h0000_0004}) begin
            failures++;
            $display("FAIL b2b_end: got done=%0b fault=%0b status=%h expected 1 0 00000004",
                     done, fault, status_word);
        end
        checks++;
        if (rises - base !== 4) begin
            failures++;
            $display("FAIL b2b_pulses: got %0d expected 4", rises - base);
        end
        checks++;
        if (dir !== 1'b0) begin
            failures++;
            $display("FAIL b2b_dir: got %0b expected 0", dir);
        end
    endtask

    task automatic test_reset_midmove;
        int base;
        base = rises;
        start_move(32'h8000_0005, 32'd200);
        wait_rises(base + 1, 500);
        tick(5);
        checks++;
        if (step !== 1'b1) begin
            failures++;
            $display("FAIL midreset_pre: got step=%0b expected 1", step);
        end
        #1 reset_reset_n = 1'b0;
        #1;
        checks++;
        if (step !== 1'b0) begin
            failures++;
            $display("FAIL midreset_step: got step=%0b expected 0", step);
        end
        checks++;
        if ({dir, done, fault, status_word} !== 35'd0) begin
            failures++;
            $display("FAIL midreset_outputs: got dir=%0b done=%0b fault=%0b status=%h expected all 0",
                     dir, done, fault, status_word);
        end
        tick(2);
        reset_reset_n = 1'b1;
        tick(3);
    endtask

`ifdef STEPPER_POS_TRACK_EN
    task automatic test_position;
        start_move(32'h8000_0005, 32'd100);
        wait_end(1000);
        checks++;
        if (position !== 32'sd5) begin
            failures++;
            $display("FAIL pos_fwd: got %0d expected 5", position);
        end
        start_move(32'h0000_0002, 32'd100);
        wait_end(1000);
        checks++;
        if (position !== 32'sd3) begin
            failures++;
            $display("FAIL pos_net: got %0d expected 3", position);
        end
        endstop_min_n = 1'b0;
        tick(5);
        checks++;
        if (position !== 32'sd0) begin
            failures++;
            $display("FAIL pos_home: got %0d expected 0", position);
        end
        endstop_min_n = 1'b1;
        tick(3);
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_clamp();
        test_zero();
        test_endstop_dir0();
        test_endstop_dir1();
        test_abort();
        test_back_to_back();
        test_reset_midmove();
`ifdef STEPPER_POS_TRACK_EN
        test_position();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
